// File: rtl/dsp_step_scheduler.sv
// Per-sample DSP step scheduler: 64-step slot sequencer for 8 voices, echo and
// source-directory fetches, with shared-RAM arbitration against the CPU.
module dsp_step_scheduler #(
  parameter int unsigned N_VOICES = 8,
  parameter int unsigned N_STEPS  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [5:0] step,
  output logic       sample_tick,
  output logic       init_valid,
  output logic [2:0] init_voice,
  output logic       hdr_valid,
  output logic [2:0] hdr_voice,
  output logic       data_valid,
  output logic [2:0] data_voice,
  output logic [1:0] data_idx,
  output logic       proc_valid,
  output logic [2:0] proc_voice,
  output logic [1:0] proc_idx,
  output logic       echo_valid,
  output logic [2:0] echo_idx,
  output logic       src_valid,
  output logic [2:0] src_voice,
  output logic [2:0] src_idx,
  input  logic       cpu_req,
  output logic       cpu_grant,
  output logic [1:0] ram_owner
);

  localparam int unsigned STEP_W     = 6;
  localparam int unsigned VOICE_W    = 3;
  localparam int unsigned LAST_STEP  = N_STEPS - 1;
  localparam int unsigned VOICE_SPAN = 4 * N_VOICES;
  localparam int unsigned HDR_LAST   = VOICE_SPAN - 3;
  localparam int unsigned PROC_LAST  = VOICE_SPAN + 4;
  localparam int unsigned ECHO_FIRST = VOICE_SPAN + 1;
  localparam int unsigned ECHO_LAST  = ECHO_FIRST + 7;
  localparam int unsigned SRC_FIRST  = ECHO_LAST + 1;
  localparam int unsigned SRC_LAST   = SRC_FIRST + 5;

  logic [STEP_W-1:0]  r_step;
  logic [VOICE_W-1:0] r_src_voice;

  logic       w_active;
  logic       w_last;
  logic [4:0] w_hdr_off;
  logic [4:0] w_data_off;
  logic [4:0] w_proc_off;
  logic       w_voice_busy;
  logic       w_glob_busy;

  assign step     = r_step;
  assign w_active = enable & ~reset;
  assign w_last   = (r_step == STEP_W'(LAST_STEP));

  // Step counter and per-sample source-directory voice pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_step      <= '0;
      r_src_voice <= '0;
    end else if (enable) begin
      r_step <= w_last ? '0 : r_step + STEP_W'(1);
      if (w_last) r_src_voice <= r_src_voice + VOICE_W'(1);
    end
  end

  // Slot decode: offsets relative to each slot's first step give voice/idx
  always_comb begin
    w_hdr_off   = 5'(r_step - STEP_W'(1));
    w_data_off  = 5'(r_step - STEP_W'(2));
    w_proc_off  = 5'(r_step - STEP_W'(5));
    sample_tick = w_active && w_last;
    init_valid  = 1'b0;
    init_voice  = '0;
    hdr_valid   = 1'b0;
    hdr_voice   = '0;
    data_valid  = 1'b0;
    data_voice  = '0;
    data_idx    = '0;
    proc_valid  = 1'b0;
    proc_voice  = '0;
    proc_idx    = '0;
    echo_valid  = 1'b0;
    echo_idx    = '0;
    src_valid   = 1'b0;
    src_voice   = '0;
    src_idx     = '0;
    if (w_active) begin
      if (r_step < STEP_W'(VOICE_SPAN) && r_step[1:0] == 2'd0) begin
        init_valid = 1'b1;
        init_voice = r_step[4:2];
      end
      if (r_step >= STEP_W'(1) && r_step <= STEP_W'(HDR_LAST) && w_hdr_off[1:0] == 2'd0) begin
        hdr_valid = 1'b1;
        hdr_voice = w_hdr_off[4:2];
      end
      // Data idx 2 of voice v lands on voice v+1's init step; both fire
      if (r_step >= STEP_W'(2) && r_step <= STEP_W'(VOICE_SPAN) && w_data_off[1:0] != 2'd3) begin
        data_valid = 1'b1;
        data_voice = w_data_off[4:2];
        data_idx   = w_data_off[1:0];
      end
      if (r_step >= STEP_W'(5) && r_step <= STEP_W'(PROC_LAST)) begin
        proc_valid = 1'b1;
        proc_voice = w_proc_off[4:2];
        proc_idx   = w_proc_off[1:0];
      end
      if (r_step >= STEP_W'(ECHO_FIRST) && r_step <= STEP_W'(ECHO_LAST)) begin
        echo_valid = 1'b1;
        echo_idx   = 3'(r_step - STEP_W'(ECHO_FIRST));
      end
      if (r_step >= STEP_W'(SRC_FIRST) && r_step <= STEP_W'(SRC_LAST)) begin
        src_valid = 1'b1;
        src_voice = r_src_voice;
        src_idx   = 3'(r_step - STEP_W'(SRC_FIRST));
      end
    end
  end

  // RAM arbitration: CPU only gets free steps unless the DSP is stalled
  always_comb begin
    w_voice_busy = (r_step >= STEP_W'(1)) && (r_step <= STEP_W'(VOICE_SPAN));
    w_glob_busy  = (r_step >= STEP_W'(ECHO_FIRST)) && (r_step <= STEP_W'(SRC_LAST));
    cpu_grant    = ~reset & cpu_req & (~(w_voice_busy | w_glob_busy) | ~enable);
    ram_owner    = 2'd0;
    if (cpu_grant)                    ram_owner = 2'd3;
    else if (w_active && w_voice_busy) ram_owner = 2'd1;
    else if (w_active && w_glob_busy)  ram_owner = 2'd2;
  end

endmodule

// File: tb/tb_dsp_step_scheduler.sv
// Bench for dsp_step_scheduler: directed scenarios plus random enable/req/reset,
// every cycle checked against a slot-table reference model.
module tb_dsp_step_scheduler;

  logic       clock = 1'b0;
  logic       reset, enable, cpu_req;
  logic [5:0] step;
  logic       sample_tick;
  logic       init_valid, hdr_valid, data_valid, proc_valid, echo_valid, src_valid;
  logic [2:0] init_voice, hdr_voice, data_voice, proc_voice, src_voice;
  logic [1:0] data_idx, proc_idx;
  logic [2:0] echo_idx, src_idx;
  logic       cpu_grant;
  logic [1:0] ram_owner;

  int total = 0;
  int bad   = 0;
  int m_step = 0;
  int m_src  = 0;

  always #5 clock = ~clock;

  dsp_step_scheduler #(.N_VOICES(8), .N_STEPS(64)) dut (
    .clock(clock), .reset(reset), .enable(enable), .step(step),
    .sample_tick(sample_tick),
    .init_valid(init_valid), .init_voice(init_voice),
    .hdr_valid(hdr_valid), .hdr_voice(hdr_voice),
    .data_valid(data_valid), .data_voice(data_voice), .data_idx(data_idx),
    .proc_valid(proc_valid), .proc_voice(proc_voice), .proc_idx(proc_idx),
    .echo_valid(echo_valid), .echo_idx(echo_idx),
    .src_valid(src_valid), .src_voice(src_voice), .src_idx(src_idx),
    .cpu_req(cpu_req), .cpu_grant(cpu_grant), .ram_owner(ram_owner)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at model step %0d: observed=%0d expected=%0d", tag, m_step, obs, exp);
    end
  endtask

  // Reference: walk the per-voice slot table for the current step
  task automatic check_all(input logic rst, input logic en, input logic req);
    int iv, ivo, hv, hvo, dv, dvo, di, pv, pvo, pi, ev, ei, sv, svo, si;
    int busy, gr, own;
    logic act;
    act = en && !rst;
    iv = 0; ivo = 0; hv = 0; hvo = 0; dv = 0; dvo = 0; di = 0;
    pv = 0; pvo = 0; pi = 0; ev = 0; ei = 0; sv = 0; svo = 0; si = 0;
    if (act) begin
      for (int v = 0; v < 8; v++) begin
        if (m_step == 4*v)     begin iv = 1; ivo = v; end
        if (m_step == 4*v + 1) begin hv = 1; hvo = v; end
        for (int k = 0; k < 3; k++)
          if (m_step == 4*v + 2 + k) begin dv = 1; dvo = v; di = k; end
        for (int k = 0; k < 4; k++)
          if (m_step == 4*v + 5 + k) begin pv = 1; pvo = v; pi = k; end
      end
      if (m_step >= 33 && m_step <= 40) begin ev = 1; ei = m_step - 33; end
      if (m_step >= 41 && m_step <= 46) begin sv = 1; svo = m_src; si = m_step - 41; end
    end
    busy = (m_step >= 1 && m_step <= 46) ? 1 : 0;
    gr   = (!rst && req && (busy == 0 || !en)) ? 1 : 0;
    own  = rst ? 0 : gr ? 3 : (act && busy != 0) ? ((m_step <= 32) ? 1 : 2) : 0;
    chk("step",        8'(step),        8'(m_step));
    chk("sample_tick", 8'(sample_tick), 8'((act && m_step == 63) ? 1 : 0));
    chk("init_valid",  8'(init_valid),  8'(iv));
    chk("init_voice",  8'(init_voice),  8'(ivo));
    chk("hdr_valid",   8'(hdr_valid),   8'(hv));
    chk("hdr_voice",   8'(hdr_voice),   8'(hvo));
    chk("data_valid",  8'(data_valid),  8'(dv));
    chk("data_voice",  8'(data_voice),  8'(dvo));
    chk("data_idx",    8'(data_idx),    8'(di));
    chk("proc_valid",  8'(proc_valid),  8'(pv));
    chk("proc_voice",  8'(proc_voice),  8'(pvo));
    chk("proc_idx",    8'(proc_idx),    8'(pi));
    chk("echo_valid",  8'(echo_valid),  8'(ev));
    chk("echo_idx",    8'(echo_idx),    8'(ei));
    chk("src_valid",   8'(src_valid),   8'(sv));
    chk("src_voice",   8'(src_voice),   8'(svo));
    chk("src_idx",     8'(src_idx),     8'(si));
    chk("cpu_grant",   8'(cpu_grant),   8'(gr));
    chk("ram_owner",   8'(ram_owner),   8'(own));
    chk("one_ram_user", 8'(int'(hdr_valid) + int'(data_valid) + int'(echo_valid) + int'(src_valid) > 1), 8'(0));
  endtask

  // Apply inputs, check mid-cycle, clock, advance the model
  task automatic do_cycle(input logic rst, input logic en, input logic req);
    reset = rst; enable = en; cpu_req = req;
    #1;
    check_all(rst, en, req);
    if (!rst && en && m_step == 4) begin
      chk("s4_data_voice", 8'(data_voice), 8'(0));
      chk("s4_data_idx",   8'(data_idx),   8'(2));
      chk("s4_init_voice", 8'(init_voice), 8'(1));
      chk("s4_ram_owner",  8'(ram_owner),  8'(1));
    end
    if (!rst && en && m_step == 8) begin
      chk("s8_proc_voice", 8'(proc_voice), 8'(0));
      chk("s8_proc_idx",   8'(proc_idx),   8'(3));
      chk("s8_data_voice", 8'(data_voice), 8'(1));
      chk("s8_init_voice", 8'(init_voice), 8'(2));
    end
    @(posedge clock);
    if (rst) begin
      m_step = 0;
      m_src  = 0;
    end else if (en) begin
      if (m_step == 63) m_src = (m_src + 1) % 8;
      m_step = (m_step + 1) % 64;
    end
    #1;
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 130 && m_step != target; g++) do_cycle(1'b0, 1'b1, 1'b0);
    chk("run_to_reached", 8'(step), 8'(target));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cpu_req = 1'b0;
    @(posedge clock); #1;
    do_cycle(1'b1, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1);
    // Nine full samples: whole slot table and src_voice rotation 0..7,0
    for (int i = 0; i < 9 * 64; i++) do_cycle(1'b0, 1'b1, 1'b0);
    // CPU request held across the busy window
    run_to(10);
    for (int i = 0; i < 56; i++) do_cycle(1'b0, 1'b1, 1'b1);
    // Stall at step 20 for 5 clocks
    run_to(20);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'(i % 2));
    chk("resume_step", 8'(step), 8'(20));
    do_cycle(1'b0, 1'b1, 1'b0);
    chk("resumed_21", 8'(step), 8'(21));
    // Reset mid-sample at step 37
    run_to(37);
    do_cycle(1'b1, 1'b1, 1'b0);
    chk("post_reset_step", 8'(step), 8'(0));
    for (int i = 0; i < 64; i++) do_cycle(1'b0, 1'b1, 1'b0);
    // Random enable / cpu_req / occasional reset
    for (int i = 0; i < 4000; i++)
      do_cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
